// File: rtl/arm_pkg.sv
// Shared ARM pipeline types and constants.
package arm_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetch_state_t;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory,
// and holds one fetched word until the pipeline takes it.
module if_fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        fetch_stall
);

    // Memory handshake: imem_req rises with imem_addr and both hold until the
    // single-cycle imem_ack, which carries imem_rdata in the same cycle.
    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc;
    logic         buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'h0;
            buf_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        pc       <= branch_addr;
                        req_addr <= branch_addr;
                    end else begin
                        req_addr <= pc;
                    end
                    buf_valid <= 1'b0;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (branch_taken) begin
                        pc        <= branch_addr;
                        buf_valid <= 1'b0;
                        if (imem_ack) begin
                            req_addr <= branch_addr;
                            state    <= FETCH;
                        end else begin
                            // Request still outstanding at the stale address.
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        buf_instr <= imem_rdata;
                        buf_pc    <= pc + PC_STEP;
                        buf_valid <= 1'b1;
                        pc        <= pc + PC_STEP;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc        <= branch_addr;
                        buf_valid <= 1'b0;
                        req_addr  <= branch_addr;
                        state     <= FETCH;
                    end else if (!freeze) begin
                        buf_valid <= 1'b0;
                        req_addr  <= pc;
                        state     <= FETCH;
                    end
                end
                DISCARD: begin
                    if (branch_taken) begin
                        pc        <= branch_addr;
                        buf_valid <= 1'b0;
                        if (imem_ack) begin
                            req_addr <= branch_addr;
                            state    <= FETCH;
                        end
                    end else if (imem_ack) begin
                        req_addr <= pc;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req        = (state == FETCH) || (state == DISCARD);
    assign imem_addr       = req_addr;
    assign instruction_out = buf_valid ? buf_instr : NOP_INSTR;
    assign pc_out          = buf_valid ? buf_pc : 32'h0;
    assign fetch_stall     = ~buf_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a random
// run checked against a fetch-stream model.
module tb_if_fetch_stage;
    import arm_pkg::*;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        fetch_stall;

    int checks;
    int failures;

    if_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instruction_out(instruction_out),
        .pc_out(pc_out),
        .fetch_stall(fetch_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_1005;
        return {~a[15:0], a[31:16]} ^ 32'h5A5A_0001;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // From a FETCH cycle, complete n zero-wait fetches with freeze low.
    task automatic zero_wait_fetches(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            next_cycle();
            imem_ack = 1'b0;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        checks++;
        if (imem_req !== 1'b0 || instruction_out !== 32'h0 || pc_out !== 32'h0 ||
            fetch_stall !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b addr=%h instr=%h pc=%h stall=%b required 0/0/0/0/1",
                     imem_req, imem_addr, instruction_out, pc_out, fetch_stall);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || fetch_stall !== 1'b1) begin
                failures++;
                $display("FAIL seq_req%0d: req=%b addr=%h stall=%b required 1/%h/1",
                         k, imem_req, imem_addr, fetch_stall, 32'(4 * k));
            end
            next_cycle();
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            next_cycle();
            imem_ack = 1'b0;
            checks++;
            if (instruction_out !== mem_word(32'(4 * k)) || pc_out !== 32'(4 * k + 4) ||
                fetch_stall !== 1'b0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL seq_present%0d: instr=%h pc=%h stall=%b req=%b required %h/%h/0/0",
                         k, instruction_out, pc_out, fetch_stall, imem_req,
                         mem_word(32'(4 * k)), 32'(4 * k + 4));
            end
            next_cycle();
        end
    endtask

    task automatic test_freeze();
        do_reset();
        next_cycle();
        imem_ack   = 1'b1;
        imem_rdata = 32'hE3A0_1005;
        freeze     = 1'b1;
        next_cycle();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (instruction_out !== 32'hE3A0_1005 || pc_out !== 32'h4 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL freeze_hold%0d: instr=%h pc=%h req=%b required e3a01005/4/0",
                         i, instruction_out, pc_out, imem_req);
            end
            next_cycle();
        end
        freeze = 1'b0;
        next_cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fetch_stall !== 1'b1) begin
            failures++;
            $display("FAIL freeze_release: req=%b addr=%h stall=%b required 1/4/1",
                     imem_req, imem_addr, fetch_stall);
        end
    endtask

    task automatic test_branch_discard();
        do_reset();
        next_cycle();
        zero_wait_fetches(2);
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        next_cycle();
        branch_taken = 1'b0;
        checks++;
        if (dut.state !== DISCARD || imem_req !== 1'b1 || imem_addr !== 32'h8 || fetch_stall !== 1'b1) begin
            failures++;
            $display("FAIL discard_enter: state=%0d req=%b addr=%h stall=%b required DISCARD/1/8/1",
                     dut.state, imem_req, imem_addr, fetch_stall);
        end
        next_cycle();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h8);
        next_cycle();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || fetch_stall !== 1'b1 || instruction_out !== 32'h0) begin
            failures++;
            $display("FAIL discard_drop: req=%b addr=%h stall=%b instr=%h required 1/40/1/0",
                     imem_req, imem_addr, fetch_stall, instruction_out);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h40);
        next_cycle();
        imem_ack = 1'b0;
        checks++;
        if (instruction_out !== mem_word(32'h40) || pc_out !== 32'h44) begin
            failures++;
            $display("FAIL discard_target: instr=%h pc=%h required %h/44",
                     instruction_out, pc_out, mem_word(32'h40));
        end
    endtask

    task automatic test_branch_with_ack();
        do_reset();
        next_cycle();
        zero_wait_fetches(3);
        imem_ack     = 1'b1;
        imem_rdata   = mem_word(imem_addr);
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        next_cycle();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_stall !== 1'b1 || instruction_out !== 32'h0) begin
            failures++;
            $display("FAIL branch_ack: req=%b addr=%h stall=%b instr=%h required 1/100/1/0",
                     imem_req, imem_addr, fetch_stall, instruction_out);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h100);
        next_cycle();
        imem_ack = 1'b0;
        checks++;
        if (instruction_out !== mem_word(32'h100) || pc_out !== 32'h104) begin
            failures++;
            $display("FAIL branch_ack_target: instr=%h pc=%h required %h/104",
                     instruction_out, pc_out, mem_word(32'h100));
        end
    endtask

    task automatic test_branch_in_hold();
        do_reset();
        next_cycle();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h0);
        freeze     = 1'b1;
        next_cycle();
        imem_ack     = 1'b0;
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        next_cycle();
        branch_taken = 1'b0;
        checks++;
        if (instruction_out !== 32'h0 || pc_out !== 32'h0 || fetch_stall !== 1'b1 ||
            imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL hold_branch: instr=%h pc=%h stall=%b req=%b addr=%h required 0/0/1/1/200",
                     instruction_out, pc_out, fetch_stall, imem_req, imem_addr);
        end
        freeze = 1'b0;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        next_cycle();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        next_cycle();
        branch_taken = 1'b0;
        zero_wait_fetches(0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_stale: req=%b addr=%h required 1/0", imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h0);
        next_cycle();
        imem_ack = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        next_cycle();
        imem_ack = 1'b0;
        checks++;
        if (instruction_out !== mem_word(32'hFFFF_FFFC) || pc_out !== 32'h0 || fetch_stall !== 1'b0) begin
            failures++;
            $display("FAIL wrap_present: instr=%h pc=%h stall=%b required %h/0/0",
                     instruction_out, pc_out, fetch_stall, mem_word(32'hFFFF_FFFC));
        end
        next_cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: req=%b addr=%h required 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        next_cycle();
        zero_wait_fetches(8);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            failures++;
            $display("FAIL midrst_setup: req=%b addr=%h required 1/20", imem_req, imem_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instruction_out !== 32'h0 ||
            pc_out !== 32'h0 || fetch_stall !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async: req=%b addr=%h instr=%h pc=%h stall=%b required 0/0/0/0/1",
                     imem_req, imem_addr, instruction_out, pc_out, fetch_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL midrst_restart: req=%b addr=%h required 1/0", imem_req, imem_addr);
        end
    endtask

    // Random memory latency, freeze and branches; the model only tracks which
    // address the next presented instruction must come from.
    task automatic test_random();
        logic [31:0] exp_stream;
        logic [31:0] held_addr;
        logic        held;
        int          wait_cnt;
        int          lat;
        int          consumed;
        do_reset();
        exp_stream = 32'h0;
        held       = 1'b0;
        held_addr  = 32'h0;
        wait_cnt   = 0;
        lat        = $urandom_range(0, 3);
        consumed   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if (!fetch_stall) begin
                if (instruction_out !== mem_word(exp_stream) || pc_out !== exp_stream + 32'd4) begin
                    failures++;
                    $display("FAIL rand_present cyc=%0d: instr=%h pc=%h required %h/%h",
                             cyc, instruction_out, pc_out, mem_word(exp_stream), exp_stream + 32'd4);
                end
            end else if (instruction_out !== 32'h0 || pc_out !== 32'h0) begin
                failures++;
                $display("FAIL rand_bubble cyc=%0d: instr=%h pc=%h required 0/0",
                         cyc, instruction_out, pc_out);
            end
            if (held && imem_req) begin
                checks++;
                if (imem_addr !== held_addr) begin
                    failures++;
                    $display("FAIL rand_addr_stable cyc=%0d: addr=%h required %h",
                             cyc, imem_addr, held_addr);
                end
            end
            if (imem_req && wait_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
                lat        = $urandom_range(0, 3);
                held       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                if (imem_req) begin
                    wait_cnt++;
                    held      = 1'b1;
                    held_addr = imem_addr;
                end else begin
                    wait_cnt = 0;
                    held     = 1'b0;
                end
            end
            freeze       = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 15) == 0);
            branch_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            if (branch_taken) exp_stream = branch_addr;
            else if (!fetch_stall && !freeze) begin
                exp_stream = exp_stream + 32'd4;
                consumed++;
            end
            next_cycle();
        end
        branch_taken = 1'b0;
        freeze       = 1'b0;
        imem_ack     = 1'b0;
        checks++;
        if (consumed < 50) begin
            failures++;
            $display("FAIL rand_progress: consumed=%0d required at least 50", consumed);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        test_reset();
        test_sequential();
        test_freeze();
        test_branch_discard();
        test_branch_with_ack();
        test_branch_in_hold();
        test_pc_wrap();
        test_reset_mid_handshake();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the ARM 5-stage pipeline. Sits directly upstream of the IF/ID pipeline register and feeds its instruction_in and pcin inputs.
- Owns the PC and runs a req/ack handshake to a variable-latency instruction memory.
- Holds the fetched word in a one-entry buffer until the pipeline accepts it (~freeze).
- Redirects on a taken branch from EXE and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard-unit stall; while high, the buffered instruction is not consumed.
- branch_taken  in  1  single-cycle redirect pulse from EXE.
- branch_addr  in  32  redirect target, valid when branch_taken=1.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  single-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instruction_out  out  32  to IF/ID instruction_in; 32'h0 (bubble) when no valid instruction.
- pc_out  out  32  to IF/ID pcin; address of the fetched instruction + PC_STEP, or 0 when no valid instruction.
- fetch_stall  out  1  high when no valid instruction is presented (status/perf only).

Behaviour:
- Internal state: pc, req_addr, buf_instr, buf_pc, buf_valid, state.
- State encoding is {IDLE, FETCH, HOLD, DISCARD}.
- Reset (async): pc=RESET_PC, req_addr=RESET_PC, buf_valid=0, buf_instr=0, buf_pc=0, state=IDLE. Resulting outputs: imem_req=0, instruction_out=0, pc_out=0, fetch_stall=1.
- Reset mid-handshake abandons the outstanding request. The memory must tolerate req dropping.
- Outputs are combinational from registers only:
  - imem_req = (state==FETCH || state==DISCARD).
  - imem_addr = req_addr.
  - instruction_out = buf_valid ? buf_instr : 0.
  - pc_out = buf_valid ? buf_pc : 0.
  - fetch_stall = ~buf_valid.
- IDLE: next cycle goes to FETCH with req_addr=pc. Occurs only after reset.
- FETCH: on imem_ack with no branch, load buf_instr=imem_rdata, buf_pc=pc+PC_STEP, buf_valid=1, pc=pc+PC_STEP; go to HOLD. Without ack, stay in FETCH.
- HOLD: if ~freeze, the buffer is consumed this edge (IF/ID captures it); set buf_valid=0, req_addr=pc, and go to FETCH. If freeze, hold everything.
- DISCARD: imem_req stays high on the abandoned req_addr. On imem_ack, drop the data, set req_addr=pc, and go to FETCH.
- branch_taken has priority over freeze and over ack. In every state it sets pc=branch_addr and buf_valid=0. Transitions:
  - In FETCH without ack: go to DISCARD; req_addr is unchanged.
  - In FETCH with ack in the same cycle: drop the data, set req_addr=branch_addr, go to FETCH.
  - In HOLD: set req_addr=branch_addr, go to FETCH.
  - In DISCARD without ack: stay in DISCARD with pc updated.
  - In DISCARD with ack: set req_addr=branch_addr, go to FETCH.
  - In IDLE: set pc=branch_addr, go to FETCH.
- Latency: an ack at edge N presents the instruction in cycle N+1.
- Peak throughput is one instruction per 2 cycles with a zero-wait memory.
- Bubble output while empty: IF/ID captures NOP 32'h0 each cycle it is not frozen.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- branch_addr is used as given; bits [1:0] are not checked.
- The top level flushes IF/ID on the same branch_taken pulse. This block only guarantees that no pre-branch instruction is presented after the redirect edge.

Decomposition:
- Shared package arm_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, HOLD, DISCARD}.
  - NOP_INSTR = 32'h0.
  - Default PC_STEP constant.
- Single module; no sub-module needed. The PC/redirect logic is too small to justify splitting out.

Test Plan:
- Reset release, memory acks 1 cycle after req, freeze=0 → imem_addr sequence 0,4,8. instruction_out shows each word one cycle after its ack, with pc_out=4,8,12. fetch_stall alternates 1/0.
- Instruction 0xE3A01005 buffered, freeze held 3 cycles → instruction_out and pc_out stable, imem_req=0 throughout. Releasing freeze gives the next req at addr 4.
- Request at addr 8 outstanding, branch_taken with branch_addr=0x40, ack 2 cycles later → state DISCARD, imem_addr stays 8, ack data dropped. The next req is at 0x40, and no 0x8 instruction ever appears.
- branch_taken coincident with imem_ack at addr 12 → data dropped, next req at branch_addr=0x100, buf_valid=0.
- branch_taken during HOLD with freeze=1 → buffer cleared (instruction_out=0) despite freeze. The next req is at the target.
- rst asserted while imem_req=1 at addr 0x20 → all outputs return to reset values immediately. After release, the first fetch is at RESET_PC.
